ball_mover: RTL and testbench
=============================

Name: ball_mover

Overview:
- Per-frame ball position engine that feeds the ball renderer.
- Holds position, velocity and active flag for up to CNT balls and accepts launches of new balls.
- On each frame tick it walks the balls sequentially, one per clock: integrates velocity, bounces off walls and the paddle, and retires balls that fall off the bottom.
- Outputs xs/ys/balls in the same packed format the renderer consumes.

Parameters:
- CNT, 3, number of ball slots.
- XMAX, 640, screen width in pixels.
- YMAX, 480, screen height in pixels.
- PADDLE_Y, 440, y of paddle top surface.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- size  in  6  ball radius, pixels.
- launch_valid  in  1  launch request.
- launch_ready  out  1  high when a launch is accepted this cycle.
- launch_slot  in  $clog2(CNT)  target slot.
- launch_x  in  10  initial x.
- launch_y  in  10  initial y.
- launch_vx  in  4  initial x velocity, signed.
- launch_vy  in  4  initial y velocity, signed.
- paddle_x  in  10  paddle left edge.
- paddle_w  in  10  paddle width.
- xs  out  CNT*10  packed x, slot i at [i*10+:10].
- ys  out  CNT*10  packed y, slot i at [i*10+:10].
- balls  out  CNT  active flags.
- busy  out  1  update sweep in progress.
- done  out  1  one-cycle pulse at end of sweep.
- lost  out  CNT  one-cycle pulse per slot retired this sweep.
- overrun  out  1  sticky: frame_tick arrived while busy.

Behaviour:
- Reset (async, rst_n=0): xs, ys, balls, all velocities, busy, done, lost and overrun are 0. FSM state is IDLE.
- FSM states are IDLE, UPDATE and DONE.
  - IDLE: frame_tick=1 moves to UPDATE with idx=0.
  - UPDATE: processes slot idx each cycle. When idx=CNT-1 it moves to DONE.
  - DONE: done=1 for one cycle, then returns to IDLE.
- busy is high in UPDATE and DONE.
- launch_ready = (state==IDLE).
- Latency: tick sampled at cycle T → slot i's new values visible at T+2+i; done high in cycle T+CNT+1.
- Launch:
  - Accepted when launch_valid & launch_ready.
  - Writes the slot's position and velocity and sets balls[slot]=1.
  - Overwrites an already active slot.
  - launch_slot ≥ CNT is ignored.
- Simultaneous launch and frame_tick in IDLE: both are accepted. The launched ball is included in this sweep.
- frame_tick while busy is ignored and sets overrun=1. overrun clears only on reset.
- Update of slot i (skipped entirely if balls[i]=0):
  - Compute nx = x+vx and ny = y+vy in 12-bit signed; vx and vy are sign-extended.
  - Left wall: if nx < size, then nx=size and vx=-vx.
  - Right wall: if nx > XMAX-1-size, then nx=XMAX-1-size and vx=-vx.
  - Top wall: if ny < size, then ny=size and vy=-vy.
  - Bottom loss: if ny ≥ YMAX, then balls[i]=0 and lost[i]=1; position is held unchanged.
  - Velocity negation saturates: -(-8)=7.
  - Both x and y bounces in one step (corner) are applied together.
- lost bits are set during the sweep. They are cleared on the cycle after done, and on the tick that starts the next sweep.
- Zero-velocity balls remain stationary and active.

Optional Feature:
- BALL_PADDLE_EN defined: paddle bounce is active.
  - Condition: vy>0, y+size < PADDLE_Y, ny+size ≥ PADDLE_Y, and paddle_x ≤ nx < paddle_x+paddle_w.
  - Result: ny=PADDLE_Y-size-1 and vy=-vy.
  - Evaluated before the loss check.
- Not defined: paddle_x and paddle_w are ignored; balls pass through to the loss check.

Test Plan:
- Reset, then launch slot 0 at (100,100) with v=(2,3), size=4, then one tick → xs[0]=102, ys[0]=103 at T+2; done at T+4.
- Ball at x=634, vx=5, size=4, tick → x=635, vx=-5 (right wall clamp).
- Ball at y=478, vy=3, tick → balls[0]=0, lost=3'b001 for one cycle; next tick leaves slot 0 untouched.
- BALL_PADDLE_EN: ball (200,434), vy=4, size=4, paddle_x=180, paddle_w=40 → y=435, vy=-4. Without the macro the ball continues down.
- Second frame_tick at T+1 during sweep → ignored, overrun=1 until reset.
- launch_valid and frame_tick in the same IDLE cycle for slot 2 at (50,50), v=(1,1) → ys[2]=51 at T+4; launch_ready low through DONE.

Source files
------------

// File: rtl/ball_mover.sv
`default_nettype none
// ============================================================================
// Module      : ball_mover
// Description : Per-frame ball position engine feeding the ball renderer.
//               Keeps position, velocity and an active flag for CNT ball
//               slots. On each frame_tick it walks the slots one per clock.
//               For each active slot it integrates velocity, bounces off the
//               left, right and top walls (and the paddle when enabled), and
//               retires balls that fall past the bottom of the screen.
// Options     : `define BALL_PADDLE_EN enables the paddle bounce. Without it,
//               paddle_x and paddle_w are ignored.
// Ports       : clk, rst_n (async, active low)
//               frame_tick          - starts a sweep when idle
//               size                - ball radius in pixels
//               launch_*            - slot write request (accepted when idle)
//               paddle_x/paddle_w   - paddle span on the paddle row
//               xs/ys               - packed positions, slot i at [i*10+:10]
//               balls               - active flags
//               busy/done           - sweep in progress / end-of-sweep pulse
//               lost                - slots retired during the current sweep
//               overrun             - sticky: tick arrived during a sweep
// Revision    : 1.0 - initial release
// ============================================================================
module ball_mover #(
    parameter  int CNT      = 3,
    parameter  int XMAX     = 640,
    parameter  int YMAX     = 480,
    parameter  int PADDLE_Y = 440,
    localparam int SW       = (CNT > 1) ? $clog2(CNT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic [5:0]        size,
    input  logic              launch_valid,
    output logic              launch_ready,
    input  logic [SW-1:0]     launch_slot,
    input  logic [9:0]        launch_x,
    input  logic [9:0]        launch_y,
    input  logic [3:0]        launch_vx,
    input  logic [3:0]        launch_vy,
    input  logic [9:0]        paddle_x,
    input  logic [9:0]        paddle_w,
    output logic [CNT*10-1:0] xs,
    output logic [CNT*10-1:0] ys,
    output logic [CNT-1:0]    balls,
    output logic              busy,
    output logic              done,
    output logic [CNT-1:0]    lost,
    output logic              overrun
);

    localparam logic signed [11:0] c_xlim = 12'(XMAX - 1);
    localparam logic signed [11:0] c_ymax = 12'(YMAX);
    localparam logic signed [11:0] c_pady = 12'(PADDLE_Y);
    localparam logic [SW:0]        c_cnt  = (SW + 1)'(CNT);
    localparam logic [SW-1:0]      c_last = SW'(CNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        [9:0]    r_x  [CNT];
    logic        [9:0]    r_y  [CNT];
    logic signed [3:0]    r_vx [CNT];
    logic signed [3:0]    r_vy [CNT];
    logic        [CNT-1:0] r_act;
    logic        [CNT-1:0] r_lost;
    logic                 r_overrun;
    logic        [SW-1:0] r_idx;

    logic signed [11:0] w_sz, w_cx, w_cy, w_nx, w_ny;
    logic signed [3:0]  w_vx, w_vy, w_nvx, w_nvy;
    logic               w_lose;
    logic               w_slot_ok;

    // Negation of a 4-bit velocity; -(-8) has no 4-bit encoding, so it saturates to 7.
    function automatic logic signed [3:0] sat_neg(input logic signed [3:0] v);
        return (v[3] && (v[2:0] == 3'b000)) ? 4'sd7 : -v;
    endfunction

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        launch_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                launch_ready = 1'b1;
                if (frame_tick) w_next = UPDATE;
            end
            UPDATE: begin
                busy = 1'b1;
                if (r_idx == c_last) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Motion datapath for the slot currently addressed by r_idx
    // ------------------------------------------------------------------------
`ifdef BALL_PADDLE_EN
    logic signed [11:0] w_px, w_pe;
`else
    logic w_unused_paddle;
    assign w_unused_paddle = ^{paddle_x, paddle_w};
`endif

    always_comb begin
        w_vx  = r_vx[r_idx];
        w_vy  = r_vy[r_idx];
        w_sz  = {6'd0, size};
        w_cx  = {2'b00, r_x[r_idx]};
        w_cy  = {2'b00, r_y[r_idx]};
        w_nx  = w_cx + {{8{w_vx[3]}}, w_vx};
        w_ny  = w_cy + {{8{w_vy[3]}}, w_vy};
        w_nvx = w_vx;
        w_nvy = w_vy;

        if (w_nx < w_sz) begin
            w_nx  = w_sz;
            w_nvx = sat_neg(w_vx);
        end else if (w_nx > c_xlim - w_sz) begin
            w_nx  = c_xlim - w_sz;
            w_nvx = sat_neg(w_vx);
        end

        if (w_ny < w_sz) begin
            w_ny  = w_sz;
            w_nvy = sat_neg(w_vy);
        end

`ifdef BALL_PADDLE_EN
        // Only a ball moving down that crosses the paddle row this step bounces;
        // the x test uses the wall-corrected position.
        w_px = {2'b00, paddle_x};
        w_pe = w_px + {2'b00, paddle_w};
        if ((w_vy > 4'sd0) && (w_cy + w_sz < c_pady) && (w_ny + w_sz >= c_pady) &&
            (w_nx >= w_px) && (w_nx < w_pe)) begin
            w_ny  = c_pady - w_sz - 12'sd1;
            w_nvy = sat_neg(w_vy);
        end
`endif

        w_lose = (w_ny >= c_ymax);
    end

    assign w_slot_ok = ({1'b0, launch_slot} < c_cnt);

    // ------------------------------------------------------------------------
    // Slot storage, sweep index, lost/overrun flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CNT; i++) begin
                r_x[i]  <= '0;
                r_y[i]  <= '0;
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
            r_act     <= '0;
            r_lost    <= '0;
            r_overrun <= 1'b0;
            r_idx     <= '0;
        end else begin
            if ((r_state == IDLE) && launch_valid && w_slot_ok) begin
                r_x[launch_slot]   <= launch_x;
                r_y[launch_slot]   <= launch_y;
                r_vx[launch_slot]  <= launch_vx;
                r_vy[launch_slot]  <= launch_vy;
                r_act[launch_slot] <= 1'b1;
            end

            if (r_state == IDLE)        r_idx <= '0;
            else if (r_state == UPDATE) r_idx <= r_idx + SW'(1);

            if ((r_state == DONE) || ((r_state == IDLE) && frame_tick))
                r_lost <= '0;

            if ((r_state == UPDATE) && r_act[r_idx]) begin
                if (w_lose) begin
                    // Retired balls keep their last on-screen position.
                    r_act[r_idx]  <= 1'b0;
                    r_lost[r_idx] <= 1'b1;
                end else begin
                    r_x[r_idx]  <= w_nx[9:0];
                    r_y[r_idx]  <= w_ny[9:0];
                    r_vx[r_idx] <= w_nvx;
                    r_vy[r_idx] <= w_nvy;
                end
            end

            if (frame_tick && (r_state != IDLE)) r_overrun <= 1'b1;
        end
    end

    for (genvar g = 0; g < CNT; g++) begin : g_pack
        assign xs[g*10 +: 10] = r_x[g];
        assign ys[g*10 +: 10] = r_y[g];
    end

    assign balls   = r_act;
    assign lost    = r_lost;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ball_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_mover
// Description : Bench for ball_mover. Stimulus updates a behavioural model of
//               the ball slots and queues the expected end-of-sweep state; a
//               monitor pops and compares on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_mover;

    localparam int CNT      = 3;
    localparam int XMAX     = 640;
    localparam int YMAX     = 480;
    localparam int PADDLE_Y = 440;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              frame_tick = 1'b0;
    logic [5:0]        size = 6'd4;
    logic              launch_valid = 1'b0;
    logic              launch_ready;
    logic [1:0]        launch_slot = '0;
    logic [9:0]        launch_x = '0;
    logic [9:0]        launch_y = '0;
    logic [3:0]        launch_vx = '0;
    logic [3:0]        launch_vy = '0;
    logic [9:0]        paddle_x = '0;
    logic [9:0]        paddle_w = '0;
    logic [CNT*10-1:0] xs;
    logic [CNT*10-1:0] ys;
    logic [CNT-1:0]    balls;
    logic              busy;
    logic              done;
    logic [CNT-1:0]    lost;
    logic              overrun;

    ball_mover #(.CNT(CNT), .XMAX(XMAX), .YMAX(YMAX), .PADDLE_Y(PADDLE_Y)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .size(size),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_slot(launch_slot), .launch_x(launch_x), .launch_y(launch_y),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .paddle_x(paddle_x), .paddle_w(paddle_w),
        .xs(xs), .ys(ys), .balls(balls), .busy(busy), .done(done),
        .lost(lost), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int mx [CNT];
    int my [CNT];
    int mvx[CNT];
    int mvy[CNT];
    bit mact[CNT];
    bit m_over = 1'b0;

    typedef struct {
        logic [CNT*10-1:0] xs;
        logic [CNT*10-1:0] ys;
        logic [CNT-1:0]    balls;
        logic [CNT-1:0]    lost;
        int                due;
    } exp_t;

    exp_t sb[$];

    function automatic int sneg(input int v);
        return (v == -8) ? 7 : -v;
    endfunction

    function automatic void model_launch(input int s, input int x, input int y, input int vx, input int vy);
        if (s < CNT) begin
            mx[s] = x; my[s] = y; mvx[s] = vx; mvy[s] = vy; mact[s] = 1'b1;
        end
    endfunction

    function automatic void model_sweep(output exp_t e);
        e.lost = '0;
        for (int i = 0; i < CNT; i++) begin
            if (mact[i]) begin
                int nx, ny, vx, vy, sz;
                sz = int'(size);
                vx = mvx[i];
                vy = mvy[i];
                nx = mx[i] + vx;
                ny = my[i] + vy;
                if (nx < sz) begin
                    nx = sz; vx = sneg(vx);
                end else if (nx > XMAX - 1 - sz) begin
                    nx = XMAX - 1 - sz; vx = sneg(vx);
                end
                if (ny < sz) begin
                    ny = sz; vy = sneg(vy);
                end
`ifdef BALL_PADDLE_EN
                if (mvy[i] > 0 && my[i] + sz < PADDLE_Y && ny + sz >= PADDLE_Y &&
                    nx >= int'(paddle_x) && nx < int'(paddle_x) + int'(paddle_w)) begin
                    ny = PADDLE_Y - sz - 1; vy = sneg(mvy[i]);
                end
`endif
                if (ny >= YMAX) begin
                    mact[i]   = 1'b0;
                    e.lost[i] = 1'b1;
                end else begin
                    mx[i] = nx; my[i] = ny; mvx[i] = vx; mvy[i] = vy;
                end
            end
        end
        for (int i = 0; i < CNT; i++) begin
            e.xs[i*10 +: 10] = 10'(mx[i]);
            e.ys[i*10 +: 10] = 10'(my[i]);
            e.balls[i]       = mact[i];
        end
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers (called right after a falling edge)
    // ------------------------------------------------------------------------
    task automatic drive_launch(input int s, input int x, input int y, input int vx, input int vy);
        launch_valid = 1'b1;
        launch_slot  = 2'(s);
        launch_x     = 10'(x);
        launch_y     = 10'(y);
        launch_vx    = 4'(vx);
        launch_vy    = 4'(vy);
    endtask

    task automatic do_launch(input int s, input int x, input int y, input int vx, input int vy);
        check("launch_ready_idle", launch_ready, 1);
        drive_launch(s, x, y, vx, vy);
        model_launch(s, x, y, vx, vy);
        @(negedge clk);
        launch_valid = 1'b0;
    endtask

    task automatic do_tick(input bit with_launch, input int s, input int x, input int y,
                           input int vx, input int vy);
        exp_t e;
        frame_tick = 1'b1;
        if (with_launch) begin
            drive_launch(s, x, y, vx, vy);
            model_launch(s, x, y, vx, vy);
        end
        check("tick_ready_idle", launch_ready, 1);
        model_sweep(e);
        e.due = cyc + CNT + 1;
        sb.push_back(e);
        @(negedge clk);
        frame_tick   = 1'b0;
        launch_valid = 1'b0;
    endtask

    task automatic wait_sweep();
        int k;
        for (k = 0; k < 20; k++) begin
            if (!busy && sb.size() == 0) break;
            @(negedge clk);
        end
        if (k == 20) begin
            total++;
            bad++;
            $display("FAIL sweep_timeout: actual=busy required=idle (cycle %0d)", cyc);
        end
    endtask

    function automatic int rand_v();
        return int'($urandom_range(0, 15)) - 8;
    endfunction

    function automatic int rand_x();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 15));
            1:       return int'($urandom_range(624, 639));
            default: return int'($urandom_range(0, 639));
        endcase
    endfunction

    function automatic int rand_y();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 15));
            1:       return int'($urandom_range(420, 479));
            default: return int'($urandom_range(0, 479));
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: compares every done pulse against the queued expectation
    // ------------------------------------------------------------------------
    bit   chk_clear = 1'b0;
    exp_t me;

    always @(negedge clk) begin
        if (chk_clear) begin
            check("lost_clear_after_done", lost, 0);
            check("idle_after_done", busy, 0);
            chk_clear = 1'b0;
        end
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: actual=done required=none (cycle %0d)", cyc);
            end else begin
                me = sb.pop_front();
                check("done_cycle", cyc, me.due);
                check("sweep_xs", xs, me.xs);
                check("sweep_ys", ys, me.ys);
                check("sweep_balls", balls, me.balls);
                check("sweep_lost", lost, me.lost);
                check("busy_in_done", busy, 1);
                check("overrun_flag", overrun, m_over);
            end
            chk_clear = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int t0;
        for (int i = 0; i < CNT; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; mact[i] = 1'b0;
        end

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_xs", xs, 0);
        check("rst_ys", ys, 0);
        check("rst_balls", balls, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lost", lost, 0);
        check("rst_overrun", overrun, 0);
        check("rst_launch_ready", launch_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic integration and slot-0 latency
        size = 6'd4;
        do_launch(0, 100, 100, 2, 3);
        t0 = cyc;
        do_tick(1'b0, 0, 0, 0, 0, 0);
        check("x0_before_update", xs[9:0], 100);
        @(negedge clk);
        check("t2_cycle", cyc, t0 + 2);
        check("x0_at_t2", xs[9:0], 102);
        check("y0_at_t2", ys[9:0], 103);
        wait_sweep();

        // Right wall clamp, then reversed velocity on the next frame
        do_launch(0, 634, 200, 5, 0);
        do_tick(1'b0, 0, 0, 0, 0, 0);
        wait_sweep();
        do_tick(1'b0, 0, 0, 0, 0, 0);
        wait_sweep();

        // Bottom loss, then an untouched slot on the following frame
        do_launch(0, 300, 478, 0, 3);
        do_tick(1'b0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lost_at_t2", lost, 3'b001);
        wait_sweep();
        do_tick(1'b0, 0, 0, 0, 0, 0);
        wait_sweep();

        // Paddle row crossing
        paddle_x = 10'd180;
        paddle_w = 10'd40;
        do_launch(1, 200, 434, 0, 4);
        do_tick(1'b0, 0, 0, 0, 0, 0);
        wait_sweep();
        do_tick(1'b0, 0, 0, 0, 0, 0);
        wait_sweep();

        // Launch and tick in the same idle cycle
        t0 = cyc;
        do_tick(1'b1, 2, 50, 50, 1, 1);
        for (int k = 1; k <= 4; k++) begin
            check("ready_low_during_sweep", launch_ready, 0);
            if (k == 3) check("y2_before_update", ys[29:20], 50);
            if (k == 4) begin
                check("t4_cycle", cyc, t0 + 4);
                check("y2_at_t4", ys[29:20], 51);
            end
            if (k < 4) @(negedge clk);
        end
        wait_sweep();

        // Tick and launch while busy are both ignored; overrun becomes sticky
        check("overrun_before", overrun, 0);
        do_tick(1'b0, 0, 0, 0, 0, 0);
        frame_tick = 1'b1;
        m_over     = 1'b1;
        drive_launch(1, 10, 10, 1, 1);
        @(negedge clk);
        frame_tick   = 1'b0;
        launch_valid = 1'b0;
        check("overrun_set", overrun, 1);
        wait_sweep();
        do_tick(1'b0, 0, 0, 0, 0, 0);
        wait_sweep();

        // Randomised frames
        for (int it = 0; it < 60; it++) begin
            int n;
            size     = 6'($urandom_range(1, 12));
            paddle_x = 10'($urandom_range(0, 600));
            paddle_w = 10'($urandom_range(20, 120));
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++)
                do_launch(int'($urandom_range(0, 3)), rand_x(), rand_y(), rand_v(), rand_v());
            if ($urandom_range(0, 3) == 0)
                do_tick(1'b1, int'($urandom_range(0, 3)), rand_x(), rand_y(), rand_v(), rand_v());
            else
                do_tick(1'b0, 0, 0, 0, 0, 0);
            wait_sweep();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
